// File: rtl/keccak_pi_iter.sv
// Iterative Keccak pi / inverse-pi lane permutation: a latched state is moved
// through the selected mapping once per enabled clock, a programmable number of times.
module keccak_pi_iter #(
  parameter int  LANE_W = 64,
  parameter int  CNT_W  = 5,
  localparam int SW     = 25 * LANE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [CNT_W-1:0] in_count,
  input  logic [SW-1:0]    state_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SW-1:0]    state_out,
  output logic             busy,
  output logic [CNT_W-1:0] iter_left
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends combinationally on ready and ready never on valid.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [SW-1:0]    st_q, st_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] iter_q, iter_d;

  // out[x,y] = in[(x+3y) mod 5, x]; lane i = x+5y
  function automatic logic [SW-1:0] pi_fwd(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[(x + 5*y)*LANE_W +: LANE_W] = s[(((x + 3*y) % 5) + 5*x)*LANE_W +: LANE_W];
    return r;
  endfunction

  // out[u,v] = in[v, 2(u-v) mod 5]; the +10 keeps the dividend non-negative
  function automatic logic [SW-1:0] pi_inv(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = '0;
    for (int v = 0; v < 5; v++)
      for (int u = 0; u < 5; u++)
        r[(u + 5*v)*LANE_W +: LANE_W] = s[(v + 5*((2*(u - v) + 10) % 5))*LANE_W +: LANE_W];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= S_IDLE;
      st_q   <= '0;
      mode_q <= 1'b0;
      iter_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      st_q   <= st_d;
      mode_q <= mode_d;
      iter_q <= iter_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:  if (in_valid) fsm_d = (in_count == '0) ? S_DONE : S_RUN;
      S_RUN:   if (enable && (iter_q <= CNT_W'(1))) fsm_d = S_DONE;
      S_DONE:  if (out_ready) fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    st_d   = st_q;
    mode_d = mode_q;
    iter_d = iter_q;
    if ((fsm_q == S_IDLE) && in_valid) begin
      st_d   = state_in;
      mode_d = in_mode;
      iter_d = in_count;
    end else if ((fsm_q == S_RUN) && enable) begin
      st_d = mode_q ? pi_inv(st_q) : pi_fwd(st_q);
      if (iter_q != '0) iter_d = iter_q - CNT_W'(1);
    end
  end

  always_comb begin
    in_ready  = (fsm_q == S_IDLE);
    out_valid = (fsm_q == S_DONE);
    busy      = (fsm_q == S_RUN);
    state_out = st_q;
    iter_left = iter_q;
  end

endmodule
